// File: rtl/network_bank_out.sv
// Read-side crossbar for the 4-bank coefficient memory: returns bank k read data to lane sel_a_k,
// with the selects delayed to line up with the bank read latency.
module network_bank_out #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [1:0]        sel_a_0,
  input  logic [1:0]        sel_a_1,
  input  logic [1:0]        sel_a_2,
  input  logic [1:0]        sel_a_3,
  input  logic [DATA_W-1:0] q0,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2,
  input  logic [DATA_W-1:0] q3,
  input  logic              clr_err,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic [DATA_W-1:0] lane_2,
  output logic [DATA_W-1:0] lane_3,
  output logic              lane_vld,
  output logic              perm_err,
  output logic              err_sticky
);

  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned SEL_W     = 2;

  typedef struct packed {
    logic                            vld;
    logic [NUM_BANKS-1:0][SEL_W-1:0] sel;
  } stage_t;

  typedef logic [NUM_BANKS-1:0][DATA_W-1:0] data_vec_t;

  stage_t    dly [RD_LAT];
  stage_t    last_c;
  data_vec_t q_c;
  data_vec_t lane_c;
  data_vec_t lane_r;
  logic      dup_c;
  logic      perm_nxt_c;

  // Select/valid delay line; shifts every cycle so it tracks the bank read pipeline exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {rd_en, sel_a_3, sel_a_2, sel_a_1, sel_a_0};
      for (int unsigned i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign last_c = dly[RD_LAT-1];
  assign q_c    = {q3, q2, q1, q0};

  // Descending bank scan so the lowest matching bank is the last write and wins
  always_comb begin
    lane_c = '0;
    for (int unsigned j = 0; j < NUM_BANKS; j++) begin
      for (int k = NUM_BANKS - 1; k >= 0; k--) begin
        if (last_c.sel[k] == SEL_W'(j)) lane_c[j] = q_c[k];
      end
    end
  end

  always_comb begin
    dup_c = 1'b0;
    for (int unsigned a = 0; a < NUM_BANKS - 1; a++) begin
      for (int unsigned b = a + 1; b < NUM_BANKS; b++) begin
        if (last_c.sel[a] == last_c.sel[b]) dup_c = 1'b1;
      end
    end
  end

  assign perm_nxt_c = last_c.vld & dup_c;

  // Output register; lanes hold across invalid beats, a new error outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_r     <= '0;
      lane_vld   <= 1'b0;
      perm_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      lane_vld   <= last_c.vld;
      perm_err   <= perm_nxt_c;
      err_sticky <= perm_nxt_c | (err_sticky & ~clr_err);
      if (last_c.vld) lane_r <= lane_c;
    end
  end

  assign lane_0 = lane_r[0];
  assign lane_1 = lane_r[1];
  assign lane_2 = lane_r[2];
  assign lane_3 = lane_r[3];

endmodule
